ofmap_ctrl: RTL and testbench

OFMAP_CTRL -- requirements
Module: ofmap_ctrl

---
 rtl/ofmap_pkg.sv | 21 ++
 rtl/ofmap_obuf.sv | 52 +++++
 rtl/ofmap_ctrl.sv | 159 +++++++++++++++
 tb/tb_ofmap_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofmap_pkg.sv
// Shared types and constants for the output-feature-map controller.
// The state enum, the default sizes and the per-lane ReLU helper live here.
package ofmap_pkg;

  localparam int DATA_W = 512;
  localparam int ADDR_W = 10;
  localparam int LANE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Each lane is a signed 16-bit value; negative lanes clamp to zero.
  function automatic logic [LANE_W-1:0] relu_lane(input logic [LANE_W-1:0] lane);
    return lane[LANE_W-1] ? '0 : lane;
  endfunction

endpackage

// File: rtl/ofmap_obuf.sv
// Small circular FIFO that holds drained words between the memory read
// pipeline and the downstream ready/valid consumer.
module ofmap_obuf #(
  parameter  int WIDTH = 512,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the count alone
  // decides which entries are visible, so clearing the data buys nothing.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/ofmap_ctrl.sv
// Fill/drain controller for the ofmap memory: streams words in, then reads
// them back through a latency-tracked pipeline. Define OFMAP_CTRL_RELU_EN to
// clamp negative 16-bit lanes at the drain output.
module ofmap_ctrl #(
  parameter int DATA_W     = ofmap_pkg::DATA_W,
  parameter int ADDR_W     = ofmap_pkg::ADDR_W,
  parameter int RD_LAT     = 2,
  parameter int OBUF_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              fill_start,
  input  logic              drain_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_wraddress,
  output logic [ADDR_W-1:0] mem_rdaddress,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  import ofmap_pkg::*;

  localparam int CNT_W = $clog2(OBUF_DEPTH + 1);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   widx;
  logic [ADDR_W:0]   ridx;
  logic [ADDR_W:0]   pcnt;
  logic [RD_LAT-1:0] rd_vld;
  logic [CNT_W-1:0]  ob_count;
  logic [DATA_W-1:0] ob_head;
  logic              ob_empty;
  logic              ob_push;
  logic              ob_pop;
  logic              fill_beat;
  logic              rd_issue;
  logic              len_ok;
  logic              last_pop;
  logic              err_set;

  assign len_ok = (cfg_len != '0) && (cfg_len <= MAX_LEN);

  // NOTE: every signal written here gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    err_set  = (state != ST_IDLE) && (fill_start || drain_start);
    case (state)
      ST_IDLE: begin
        if (fill_start) begin
          if (len_ok) state_nx = ST_FILL;
          err_set = drain_start || !len_ok;
        end else if (drain_start) begin
          if (len_ok) state_nx = ST_DRAIN;
          else        err_set  = 1'b1;
        end
      end
      ST_FILL:  if (fill_beat && (widx == len_q - 1'b1)) state_nx = ST_DONE;
      ST_DRAIN: if (last_pop) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Holding reset off the write port keeps a mid-pass reset from landing a beat.
  assign in_ready      = (state == ST_FILL) && !reset;
  assign fill_beat     = in_valid && in_ready;
  assign mem_wren      = fill_beat;
  assign mem_data      = fill_beat ? in_data : '0;
  assign mem_wraddress = fill_beat ? base_q + widx[ADDR_W-1:0] : '0;

  // Reads only issue while the buffer can absorb every word already in flight.
  assign rd_issue = (state == ST_DRAIN) && (ridx < len_q) &&
                    (($countones(rd_vld) + int'(ob_count)) < OBUF_DEPTH);
  assign mem_rdaddress = rd_issue ? base_q + ridx[ADDR_W-1:0] : rd_addr_q;

  assign ob_push   = rd_vld[RD_LAT-1];
  assign out_valid = !ob_empty;
  assign ob_pop    = out_valid && out_ready;
  assign out_last  = out_valid && (state == ST_DRAIN) && (pcnt == len_q - 1'b1);
  assign last_pop  = ob_pop && out_last;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      err       <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      widx      <= '0;
      ridx      <= '0;
      pcnt      <= '0;
      rd_vld    <= '0;
      rd_addr_q <= '0;
    end else begin
      state <= state_nx;
      if (err_set) err <= 1'b1;
      if ((state == ST_IDLE) && (state_nx != ST_IDLE)) begin
        base_q <= cfg_base;
        len_q  <= cfg_len;
        widx   <= '0;
        ridx   <= '0;
        pcnt   <= '0;
      end
      if (fill_beat) widx <= widx + 1'b1;
      if (rd_issue) begin
        ridx      <= ridx + 1'b1;
        rd_addr_q <= mem_rdaddress;
      end
      if (ob_pop) pcnt <= pcnt + 1'b1;
      rd_vld <= (rd_vld << 1) | RD_LAT'(rd_issue);
    end
  end

  ofmap_obuf #(
    .WIDTH (DATA_W),
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clock     (clock),
    .reset     (reset),
    .push      (ob_push),
    .push_data (mem_q),
    .pop       (ob_pop),
    .head      (ob_head),
    .empty     (ob_empty),
    .count     (ob_count)
  );

`ifdef OFMAP_CTRL_RELU_EN
  always_comb begin
    out_data = ob_head;
    for (int l = 0; l < DATA_W / LANE_W; l++)
      out_data[l*LANE_W +: LANE_W] = relu_lane(ob_head[l*LANE_W +: LANE_W]);
  end
`else
  assign out_data = ob_head;
`endif

endmodule

// File: tb/tb_ofmap_ctrl.sv
// Randomised bench for ofmap_ctrl: a RAM model serves the memory ports and a
// word-level reference (expected memory contents) predicts every drained beat.
`timescale 1ns/1ps
module tb_ofmap_ctrl;

  localparam int DATA_W     = 512;
  localparam int ADDR_W     = 10;
  localparam int RD_LAT     = 2;
  localparam int OBUF_DEPTH = 4;
  localparam int MEM_WORDS  = 1 << ADDR_W;
  localparam int LANES      = DATA_W / 16;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] cfg_base;
  logic [ADDR_W:0]   cfg_len;
  logic              fill_start, drain_start;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid, out_ready, out_last;
  logic [DATA_W-1:0] out_data;
  logic              busy, done, err;
  logic [DATA_W-1:0] mem_data, mem_q;
  logic [ADDR_W-1:0] mem_wraddress, mem_rdaddress;
  logic              mem_wren;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] ram     [MEM_WORDS];
  logic [DATA_W-1:0] exp_mem [MEM_WORDS];
  logic [ADDR_W-1:0] rd_a1;
  logic [DATA_W-1:0] last_word;

  always #5 clock = ~clock;

  ofmap_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .OBUF_DEPTH(OBUF_DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .fill_start(fill_start), .drain_start(drain_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .err(err),
    .mem_data(mem_data), .mem_wraddress(mem_wraddress),
    .mem_rdaddress(mem_rdaddress), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  // Two-cycle synchronous RAM: address registered, then data registered.
  always @(posedge clock) begin
    if (mem_wren) ram[mem_wraddress] <= mem_data;
    rd_a1 <= mem_rdaddress;
    mem_q <= ram[rd_a1];
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] exp_out(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = w;
`ifdef OFMAP_CTRL_RELU_EN
    for (int l = 0; l < LANES; l++)
      if ($signed(w[l*16 +: 16]) < 0) r[l*16 +: 16] = 16'h0000;
`endif
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1; fill_start = 0; drain_start = 0; in_valid = 0; out_ready = 0;
    tick();
    reset = 1'b0;
  endtask

  // pattern=1 drives alternating 0xFFFE / 0x0005 lanes instead of random data.
  task automatic fill_pass(input int base, input int len, input int vprob,
                           input bit inject_drain, input bit pattern);
    int i = 0;
    int cyc = 0;
    cfg_base = ADDR_W'(base); cfg_len = (ADDR_W+1)'(len);
    fill_start = 1; in_valid = 0;
    tick();
    fill_start = 0;
    while (i < len && cyc < 4000) begin
      in_valid    = ($urandom_range(99) < vprob) || (cyc > 200);
      in_data     = pattern ? {LANES/2{16'h0005, 16'hFFFE}} : rand_word();
      drain_start = inject_drain && (cyc == 1);
      #1;
      if (cyc == 0) check("fill_in_ready", in_ready, 1);
      if (in_valid) begin
        check("fill_wren", mem_wren, 1);
        check("fill_waddr", mem_wraddress, (base + i) % MEM_WORDS);
        check("fill_wdata", mem_data, in_data);
        exp_mem[(base + i) % MEM_WORDS] = in_data;
        i++;
      end else begin
        check("fill_idle_wren", mem_wren, 0);
      end
      tick();
      drain_start = 0;
      cyc++;
    end
    check("fill_beats", i, len);
    in_valid = 1;
    #1;
    check("fill_done", done, 1);
    check("fill_done_busy", busy, 1);
    check("done_wren", mem_wren, 0);
    check("done_in_ready", in_ready, 0);
    in_valid = 0;
    tick();
    check("fill_idle_busy", busy, 0);
    check("fill_idle_done", done, 0);
  endtask

  // mode 0: out_ready held high, 1: toggled, 2: random.
  task automatic drain_pass(input int base, input int len, input int mode,
                            input bit check_lat);
    int popped = 0;
    int issued = 0;
    int cyc = 0;
    int first_valid = -1;
    logic [ADDR_W-1:0] prev_rd = '0;
    cfg_base = ADDR_W'(base); cfg_len = (ADDR_W+1)'(len);
    drain_start = 1;
    tick();
    drain_start = 0;
    while (popped < len && cyc < 4000) begin
      cyc++;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 1) : 1'($urandom_range(1));
      #1;
      // The first DRAIN cycle always issues; later issues show as a new address.
      if (cyc == 1 || mem_rdaddress != prev_rd) begin
        check("rd_addr", mem_rdaddress, (base + issued) % MEM_WORDS);
        issued++;
      end
      prev_rd = mem_rdaddress;
      check("outstanding_le_depth", (issued - popped) <= OBUF_DEPTH, 1);
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        check("out_last", out_last, popped == len - 1);
        if (out_ready) begin
          last_word = out_data;
          check("out_data", out_data, exp_out(exp_mem[(base + popped) % MEM_WORDS]));
          popped++;
        end
      end else if (mode == 0 && first_valid >= 0) begin
        check("stream_gap", out_valid, 1);
      end
      tick();
    end
    out_ready = 0;
    // cyc counts cycles after the start edge, so RD_LAT+1 edges is cycle RD_LAT+2.
    if (check_lat) check("first_valid_latency", first_valid, RD_LAT + 2);
    check("drain_beats", popped, len);
    check("drain_issued", issued, len);
    check("drain_done", done, 1);
    check("drain_done_valid", out_valid, 0);
    tick();
    check("drain_idle_busy", busy, 0);
  endtask

  initial begin
    for (int a = 0; a < MEM_WORDS; a++) begin
      ram[a] = '0;
      exp_mem[a] = '0;
    end
    cfg_base = '0; cfg_len = '0; in_data = '0;
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_waddr", mem_wraddress, 0);
    check("rst_raddr", mem_rdaddress, 0);
    check("rst_wdata", mem_data, 0);

    // Basic fill and drain of four words, then a back-pressured drain of 16.
    fill_pass(0, 4, 100, 0, 0);
    drain_pass(0, 4, 0, 1);
    fill_pass(0, 16, 70, 0, 0);
    drain_pass(0, 16, 1, 0);

    // Address wrap across the top of memory.
    fill_pass(1020, 8, 100, 0, 0);
    drain_pass(1020, 8, 0, 1);

    // Lane clamp behaviour on a fixed pattern.
    fill_pass(200, 1, 100, 0, 1);
    drain_pass(200, 1, 0, 0);
    check("lane_neg", last_word[15:0],
`ifdef OFMAP_CTRL_RELU_EN
          16'h0000);
`else
          16'hFFFE);
`endif
    check("lane_pos", last_word[31:16], 16'h0005);
    check("err_clean", err, 0);

    // Illegal commands: start during FILL, zero and oversize lengths, dual start.
    fill_pass(300, 6, 80, 1, 0);
    check("err_busy_start", err, 1);
    drain_pass(300, 6, 2, 0);
    check("err_sticky", err, 1);
    do_reset();
    check("err_cleared", err, 0);
    cfg_len = '0; fill_start = 1;
    tick();
    fill_start = 0;
    check("len0_busy", busy, 0);
    check("len0_err", err, 1);
    do_reset();
    cfg_len = 11'd1025; drain_start = 1;
    tick();
    drain_start = 0;
    check("len1025_busy", busy, 0);
    check("len1025_err", err, 1);
    do_reset();
    cfg_base = 10'd50; cfg_len = 11'd4; fill_start = 1; drain_start = 1;
    tick();
    fill_start = 0; drain_start = 0;
    #1;
    check("dual_fill_ready", in_ready, 1);
    check("dual_err", err, 1);
    do_reset();
    in_valid = 1;
    #1;
    check("abort_fill_wren", mem_wren, 0);
    in_valid = 0;

    // Reset in the middle of a stalled drain discards everything in flight.
    fill_pass(100, 16, 100, 0, 0);
    cfg_base = 10'd100; cfg_len = 11'd16; drain_start = 1;
    tick();
    drain_start = 0;
    repeat (5) tick();
    check("pre_reset_valid", out_valid, 1);
    do_reset();
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("abort_no_beats", out_valid, 0);
    end
    out_ready = 0;

    // Random fill/drain passes against the expected memory image.
    for (int t = 0; t < 6; t++) begin
      int b = $urandom_range(MEM_WORDS - 1);
      int l = $urandom_range(48, 1);
      fill_pass(b, l, $urandom_range(100, 30), 0, 0);
      drain_pass(b, l, $urandom_range(2), 0);
    end
    check("final_err", err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
